// File: rtl/uart_prog_loader_pkg.sv
// Shared constants for the UART program loader: FSM state codes, header layout, response tags.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_prog_loader_pkg;

    // FSM state codes
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_RESP_TAG = 3'd2;
    localparam logic [2:0] ST_RESP_SUM = 3'd3;
    localparam logic [2:0] ST_NAK      = 3'd4;

    // Header word layout: [31:24] opcode, [23:16] ignored, [15:0] word count
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 24;
    localparam int CNT_MSB = 15;
    localparam int CNT_LSB = 0;

    // Default opcode and response tags
    localparam logic [7:0] CMD_LOAD_DEF = 8'h4C;
    localparam logic [7:0] ACK_CODE_DEF = 8'hAC;
    localparam logic [7:0] NAK_CODE_DEF = 8'hEE;

    // Response word: tag in the top byte, count/echo field in the low half
    function automatic logic [31:0] resp_word(input logic [7:0] tag, input logic [15:0] cnt);
        return {tag, 8'h00, cnt};
    endfunction

endpackage

// File: rtl/uart_prog_loader.sv
// Pops a load header plus N payload words from the RX FIFO, writes them to instruction memory, answers tag+checksum via TX.
// Latency: memory write appears one cycle after the payload pop; o_load_done one cycle after the checksum push.
// Backpressure: RX empty holds the FSM with no write; TX full stalls the response states indefinitely.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int              DBIT      = 32,
    parameter int              ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [7:0]      CMD_LOAD  = CMD_LOAD_DEF,
    parameter logic [7:0]      ACK_CODE  = ACK_CODE_DEF,
    parameter logic [7:0]      NAK_CODE  = NAK_CODE_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_empty,
    input  logic [DBIT-1:0]   i_rx_data,
    output logic              o_rd_uart,
    input  logic              i_tx_full,
    output logic              o_wr_uart,
    output logic [DBIT-1:0]   o_tx_data,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DBIT-1:0]   o_mem_data,
    output logic              o_load_busy,
    output logic              o_load_done
);

    // Largest accepted word count is the full memory depth
    localparam logic [31:0] MAX_CNT = (ADDR_W >= 16) ? 32'h0001_0000 : (32'd1 << ADDR_W);

    logic [2:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;        // header count field, echoed in ACK/NAK
    logic [15:0]       remain_q, remain_d;  // payload words still to consume
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DBIT-1:0]   csum_q, csum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DBIT-1:0]   mem_data_q, mem_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              pop;
    logic              push;
    logic [7:0]        hdr_opc;
    logic [15:0]       hdr_cnt;
    logic              hdr_bad;

    assign pop     = ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && !i_rx_empty;
    assign push    = ((state_q == ST_RESP_TAG) || (state_q == ST_RESP_SUM) || (state_q == ST_NAK))
                     && !i_tx_full;
    assign hdr_opc = i_rx_data[OPC_MSB:OPC_LSB];
    assign hdr_cnt = i_rx_data[CNT_MSB:CNT_LSB];
    assign hdr_bad = (hdr_opc != CMD_LOAD) || ({16'd0, hdr_cnt} > MAX_CNT);

    // Next-state: header decode, payload streaming, response sequencing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        remain_d   = remain_q;
        addr_d     = addr_q;
        csum_d     = csum_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        done_d     = 1'b0;
        // busy covers the done-pulse cycle, then drops unless a new load is accepted
        busy_d     = done_q ? 1'b0 : busy_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    cnt_d    = hdr_cnt;
                    remain_d = hdr_cnt;
                    addr_d   = BASE_ADDR;
                    csum_d   = '0;
                    if (hdr_bad) begin
                        state_d = ST_NAK;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = (hdr_cnt == 16'd0) ? ST_RESP_TAG : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (pop) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = i_rx_data;
                    addr_d     = addr_q + 1'b1;
                    csum_d     = csum_q ^ i_rx_data;
                    remain_d   = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        state_d = ST_RESP_TAG;
                    end
                end
            end
            ST_RESP_TAG: begin
                if (push) begin
                    state_d = ST_RESP_SUM;
                end
            end
            ST_RESP_SUM: begin
                if (push) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_NAK: begin
                if (push) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Response word selection by state
    always_comb begin
        o_tx_data = '0;
        case (state_q)
            ST_RESP_TAG: o_tx_data = DBIT'(resp_word(ACK_CODE, cnt_q));
            ST_RESP_SUM: o_tx_data = csum_q;
            ST_NAK:      o_tx_data = DBIT'(resp_word(NAK_CODE, cnt_q));
            default:     o_tx_data = '0;
        endcase
    end

    // State registers; reset aborts any sequence in flight
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            remain_q   <= '0;
            addr_q     <= '0;
            csum_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            remain_q   <= remain_d;
            addr_q     <= addr_d;
            csum_q     <= csum_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_rd_uart   = pop;
    assign o_wr_uart   = push;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_data  = mem_data_q;
    assign o_load_busy = busy_q;
    assign o_load_done = done_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: transaction-level model of expected writes and responses.
// Latency: checks write one cycle after payload pop and done one cycle after checksum push.
// Backpressure: drives random/forced RX gaps and TX-full stalls.
module tb_uart_prog_loader;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BASE   = 0;
    localparam int LIMIT  = 6000;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_rx_empty;
    logic [31:0]       i_rx_data;
    logic              i_tx_full;
    logic              o_rd_uart;
    logic              o_wr_uart;
    logic [31:0]       o_tx_data;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_data;
    logic              o_load_busy;
    logic              o_load_done;

    always #5 i_clk = ~i_clk;

    uart_prog_loader dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx_empty  (i_rx_empty),
        .i_rx_data   (i_rx_data),
        .o_rd_uart   (o_rd_uart),
        .i_tx_full   (i_tx_full),
        .o_wr_uart   (o_wr_uart),
        .o_tx_data   (o_tx_data),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .o_load_busy (o_load_busy),
        .o_load_done (o_load_done)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic [31:0] word;
        bit          busy;
        bit          last;
    } tx_t;

    int checks   = 0;
    int failures = 0;

    logic [31:0]       rx_q[$];
    bit                rx_pay[$];
    wr_t               exp_wr[$];
    tx_t               exp_tx[$];
    logic [31:0]       act_tx[$];
    logic [ADDR_W-1:0] act_addr[$];
    logic [31:0]       cmd_pay[$];

    bit pop_pending = 0;
    bit we_due      = 0;
    bit done_due    = 0;
    bit force_full  = 0;
    bit rand_full   = 0;
    bit rand_gap    = 0;
    int gap_len     = 0;
    int gap_ctr     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what one command must produce, from the header rules alone
    task automatic send_cmd(input logic [31:0] hdr, input int npush);
        logic [15:0] n;
        bit          ok;
        logic [31:0] sum;
        tx_t         t;
        wr_t         w;
        n   = hdr[15:0];
        ok  = (hdr[31:24] == 8'h4C) && (int'(n) <= DEPTH);
        sum = 32'd0;
        rx_q.push_back(hdr);
        rx_pay.push_back(1'b0);
        if (!ok) begin
            t.word = {8'hEE, 8'h00, n};
            t.busy = 1'b0;
            t.last = 1'b0;
            exp_tx.push_back(t);
        end else begin
            for (int i = 0; i < int'(n); i++) begin
                w.addr = ADDR_W'((BASE + i) % DEPTH);
                w.data = cmd_pay[i];
                exp_wr.push_back(w);
                sum = sum ^ cmd_pay[i];
                if (i < npush) begin
                    rx_q.push_back(cmd_pay[i]);
                    rx_pay.push_back(1'b1);
                end
            end
            t.word = {8'hAC, 8'h00, n};
            t.busy = 1'b1;
            t.last = 1'b0;
            exp_tx.push_back(t);
            t.word = sum;
            t.last = 1'b1;
            exp_tx.push_back(t);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rx_q.size() != 0 || exp_tx.size() != 0 || exp_wr.size() != 0 || we_due || done_due)
               && n < LIMIT) begin
            @(negedge i_clk);
            n++;
        end
        chk("drain_in_time", 32'(n < LIMIT), 32'd1);
        repeat (3) @(negedge i_clk);
        chk("busy_idle", o_load_busy, 1'b0);
    endtask

    task automatic wait_writes(input int k);
        int n;
        n = 0;
        while (act_addr.size() < k && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk("writes_in_time", 32'(n < 200), 32'd1);
    endtask

    task automatic clear_act();
        act_tx.delete();
        act_addr.delete();
    endtask

    // RX/TX FIFO stand-in: drives inputs just after each rising edge
    initial begin
        logic [31:0] tw;
        bit          tb;
        i_rx_empty = 1'b1;
        i_rx_data  = 32'd0;
        i_tx_full  = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            if (pop_pending) begin
                tw = rx_q.pop_front();
                tb = rx_pay.pop_front();
                pop_pending = 0;
                gap_ctr = rand_gap ? int'($urandom_range(0, 2)) : gap_len;
            end
            i_rx_empty = (rx_q.size() == 0) || (gap_ctr != 0);
            if (gap_ctr != 0) gap_ctr--;
            i_rx_data  = (rx_q.size() != 0) ? rx_q[0] : $urandom();
            i_tx_full  = force_full || (rand_full && ($urandom_range(0, 3) == 0));
        end
    end

    // Compare process: every cycle against the model's queues
    initial begin
        bit  nwe;
        bit  ndone;
        tx_t t;
        wr_t w;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                pop_pending = 0;
                we_due      = 0;
                done_due    = 0;
            end else begin
                nwe   = 0;
                ndone = 0;
                chk("mem_we", o_mem_we, we_due);
                if (o_mem_we) begin
                    chk("busy_on_write", o_load_busy, 1'b1);
                    act_addr.push_back(o_mem_addr);
                    if (exp_wr.size() != 0) begin
                        w = exp_wr.pop_front();
                        chk("mem_addr", 32'(o_mem_addr), 32'(w.addr));
                        chk("mem_data", o_mem_data, w.data);
                    end
                end
                chk("load_done", o_load_done, done_due);
                if (o_load_done) chk("busy_on_done", o_load_busy, 1'b1);
                if (i_rx_empty) chk("rd_while_empty", o_rd_uart, 1'b0);
                if (i_tx_full) chk("wr_while_full", o_wr_uart, 1'b0);
                if (o_rd_uart && !i_rx_empty && rx_q.size() != 0) begin
                    pop_pending = 1;
                    nwe = rx_pay[0];
                end
                if (o_wr_uart) begin
                    act_tx.push_back(o_tx_data);
                    if (exp_tx.size() == 0) begin
                        chk("tx_spurious", o_wr_uart, 1'b0);
                    end else begin
                        t = exp_tx.pop_front();
                        chk("tx_data", o_tx_data, t.word);
                        chk("busy_on_tx", o_load_busy, t.busy);
                        ndone = t.last;
                    end
                end
                we_due   = nwe;
                done_due = ndone;
            end
        end
    end

    initial begin
        logic [31:0] hdr;
        int          kind;
        int          n;
        logic [7:0]  op;
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_mem_we", o_mem_we, 1'b0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_mem_data", o_mem_data, 32'd0);
        chk("rst_busy", o_load_busy, 1'b0);
        chk("rst_done", o_load_done, 1'b0);
        chk("rst_wr", o_wr_uart, 1'b0);
        @(posedge i_clk);
        #1 i_reset = 1'b0;

        // 3-word load
        clear_act();
        cmd_pay = '{32'h11111111, 32'h22222222, 32'h44444444};
        send_cmd(32'h4C000003, 3);
        chk("model_tag", exp_tx[0].word, 32'hAC000003);
        chk("model_sum", exp_tx[1].word, 32'h77777777);
        drain();
        chk("t1_ntx", act_tx.size(), 32'd2);
        if (act_tx.size() == 2) begin
            chk("t1_tag", act_tx[0], 32'hAC000003);
            chk("t1_sum", act_tx[1], 32'h77777777);
        end
        chk("t1_nwr", act_addr.size(), 32'd3);
        if (act_addr.size() == 3) chk("t1_last_addr", 32'(act_addr[2]), 32'd2);

        // zero-length load
        clear_act();
        cmd_pay.delete();
        send_cmd(32'h4C000000, 0);
        drain();
        chk("t2_nwr", act_addr.size(), 32'd0);
        chk("t2_ntx", act_tx.size(), 32'd2);
        if (act_tx.size() == 2) begin
            chk("t2_tag", act_tx[0], 32'hAC000000);
            chk("t2_sum", act_tx[1], 32'h00000000);
        end

        // bad opcode, then the next word is a fresh header
        clear_act();
        send_cmd(32'h12000005, 0);
        cmd_pay = '{32'hDEADBEEF};
        send_cmd(32'h4C000001, 1);
        drain();
        chk("t3_ntx", act_tx.size(), 32'd3);
        if (act_tx.size() == 3) begin
            chk("t3_nak", act_tx[0], 32'hEE000005);
            chk("t3_tag", act_tx[1], 32'hAC000001);
            chk("t3_sum", act_tx[2], 32'hDEADBEEF);
        end

        // TX full for 20 cycles
        clear_act();
        force_full = 1;
        cmd_pay = '{32'hA5A5A5A5, 32'h0F0F0F0F};
        send_cmd(32'h4C000002, 2);
        repeat (20) @(negedge i_clk);
        chk("t4_held_ntx", act_tx.size(), 32'd0);
        chk("t4_held_busy", o_load_busy, 1'b1);
        force_full = 0;
        drain();
        chk("t4_ntx", act_tx.size(), 32'd2);
        if (act_tx.size() == 2) begin
            chk("t4_tag", act_tx[0], 32'hAC000002);
            chk("t4_sum", act_tx[1], 32'hAAAAAAAA);
        end

        // 5-cycle RX gaps between payload words
        clear_act();
        gap_len = 5;
        cmd_pay = '{32'h1, 32'h2, 32'h3, 32'h4};
        send_cmd(32'h4C000004, 4);
        drain();
        gap_len = 0;
        chk("t5_nwr", act_addr.size(), 32'd4);
        for (int i = 0; i < act_addr.size() && i < 4; i++) chk("t5_addr", 32'(act_addr[i]), 32'(i));

        // reset after 2 of 4 payload words
        clear_act();
        cmd_pay = '{32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0004};
        send_cmd(32'h4C000004, 2);
        wait_writes(2);
        @(posedge i_clk);
        #1 i_reset = 1'b1;
        exp_wr.delete();
        exp_tx.delete();
        @(posedge i_clk);
        @(negedge i_clk);
        chk("rmid_mem_we", o_mem_we, 1'b0);
        chk("rmid_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rmid_mem_data", o_mem_data, 32'd0);
        chk("rmid_busy", o_load_busy, 1'b0);
        chk("rmid_done", o_load_done, 1'b0);
        chk("rmid_wr", o_wr_uart, 1'b0);
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        clear_act();
        repeat (10) @(negedge i_clk);
        chk("rmid_no_resp", act_tx.size(), 32'd0);
        cmd_pay = '{32'hCAFEF00D};
        send_cmd(32'h4C000001, 1);
        drain();
        chk("rmid_nwr", act_addr.size(), 32'd1);
        if (act_addr.size() == 1) chk("rmid_addr", 32'(act_addr[0]), 32'(BASE));
        chk("rmid_ntx", act_tx.size(), 32'd2);
        if (act_tx.size() == 2) chk("rmid_sum", act_tx[1], 32'hCAFEF00D);

        // count just over the memory depth is rejected
        clear_act();
        send_cmd(32'h4C000401, 0);
        drain();
        chk("t7_ntx", act_tx.size(), 32'd1);
        if (act_tx.size() == 1) chk("t7_nak", act_tx[0], 32'hEE000401);

        // count equal to the memory depth fills every word
        clear_act();
        cmd_pay.delete();
        for (int i = 0; i < DEPTH; i++) cmd_pay.push_back($urandom());
        send_cmd(32'h4C000400, DEPTH);
        drain();
        chk("t8_nwr", act_addr.size(), 32'(DEPTH));
        if (act_addr.size() == DEPTH) chk("t8_last_addr", 32'(act_addr[DEPTH-1]), 32'h3FF);

        // randomized commands with random gaps and TX stalls
        rand_gap  = 1;
        rand_full = 1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 5; c++) begin
                kind = int'($urandom_range(0, 3));
                cmd_pay.delete();
                if (kind == 0) begin
                    op = 8'($urandom_range(0, 255));
                    if (op == 8'h4C) op = 8'h4D;
                    hdr = {op, 8'($urandom()), 16'($urandom())};
                    send_cmd(hdr, 0);
                end else if (kind == 1) begin
                    hdr = {8'h4C, 8'($urandom()), 16'($urandom_range(1025, 65535))};
                    send_cmd(hdr, 0);
                end else begin
                    n = int'($urandom_range(0, 6));
                    for (int i = 0; i < n; i++) cmd_pay.push_back($urandom());
                    hdr = {8'h4C, 8'($urandom()), 16'(n)};
                    send_cmd(hdr, n);
                end
            end
            drain();
        end
        rand_gap  = 0;
        rand_full = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
